// File: rtl/pe_acc_tree.sv
// -----------------------------------------------------------------------------
// pe_acc_tree
//
// Reduction-and-accumulate stage behind the int16 multiplier array. Each valid
// beat carries 32 signed 32-bit lane products. They are summed through a
// three-level registered adder tree (32 -> 16 -> 4 -> 1) and then accumulated
// into an ACC_W-bit accumulator. The beat flagged "last" closes the dot product,
// and one result is emitted together with its beat count. The block has no
// backpressure.
//
// Ports
//   clk          : single clock, rising edge
//   rst_n        : asynchronous active-low reset
//   mult_valid   : beat on mult_result is valid
//   mult_last    : final beat of the dot product (qualified by mult_valid)
//   mult_result  : 32 lanes, lane i = [32i+31:32i], signed
//   acc_clr      : synchronous soft clear (flushes in-flight beats and acc)
//   out_valid    : one-cycle result strobe
//   out_result   : signed dot-product result, held between strobes
//   out_beats    : beats in the result, saturating at 65535
// -----------------------------------------------------------------------------
module pe_acc_tree #(
  parameter int ACC_W = 48
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mult_valid,
  input  logic               mult_last,
  input  logic [1023:0]      mult_result,
  input  logic               acc_clr,
  output logic               out_valid,
  output logic [ACC_W-1:0]   out_result,
  output logic [15:0]        out_beats
);

  if (ACC_W < 40 || ACC_W > 64) begin : g_bad_width
    $error("pe_acc_tree: ACC_W must be in 40..64");
  end

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // ---------------------------------------------------------------------------
  // Lane unpacking
  // ---------------------------------------------------------------------------
  logic signed [31:0] w_lane [32];

  // NOTE: every signal written in always_comb is assigned on every path;
  // a path that skipped an assignment would infer a latch.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      w_lane[i] = mult_result[32*i +: 32];
    end
  end

  // ---------------------------------------------------------------------------
  // Adder tree data registers. Widths grow one bit per doubling of addends,
  // so the 37-bit S3 sum is exact for any input.
  // ---------------------------------------------------------------------------
  logic signed [32:0] r_s1 [16];
  logic signed [34:0] r_s2 [4];
  logic signed [36:0] r_s3;

  // NOTE: the tree data registers have no reset. Their contents are only
  // consumed when the matching valid bit is set, and the valid bits are reset.
  // Leaving the wide datapath unreset keeps the reset net small.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 16; k++) begin
      r_s1[k] <= 33'(w_lane[2*k]) + 33'(w_lane[2*k+1]);
    end
    for (int j = 0; j < 4; j++) begin
      r_s2[j] <= 35'(r_s1[4*j])   + 35'(r_s1[4*j+1])
               + 35'(r_s1[4*j+2]) + 35'(r_s1[4*j+3]);
    end
    r_s3 <= 37'(r_s2[0]) + 37'(r_s2[1]) + 37'(r_s2[2]) + 37'(r_s2[3]);
  end

  // ---------------------------------------------------------------------------
  // Valid / last pipeline.
  // A beat arriving with acc_clr still enters S1 and starts the new dot
  // product. Only the beats already in S1/S2 are flushed.
  // ---------------------------------------------------------------------------
  logic r_v1, r_l1, r_v2, r_l2, r_v3, r_l3;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_l1 <= 1'b0;
      r_v2 <= 1'b0;
      r_l2 <= 1'b0;
      r_v3 <= 1'b0;
      r_l3 <= 1'b0;
    end else begin
      r_v1 <= mult_valid;
      r_l1 <= mult_valid & mult_last;
      r_v2 <= r_v1 & ~acc_clr;
      r_l2 <= r_l1 & ~acc_clr;
      r_v3 <= r_v2 & ~acc_clr;
      r_l3 <= r_l2 & ~acc_clr;
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulate stage
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] r_acc;
  logic [15:0]      r_cnt;
  logic [ACC_W-1:0] w_acc_next;
  logic [15:0]      w_cnt_next;

  // The accumulator wraps modulo 2^ACC_W. The counter saturates.
  assign w_acc_next = r_acc + {{(ACC_W-37){r_s3[36]}}, r_s3};
  assign w_cnt_next = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_beats  <= '0;
    end else if (acc_clr) begin
      // out_result / out_beats keep the last delivered result.
      r_acc     <= '0;
      r_cnt     <= '0;
      out_valid <= 1'b0;
    end else if (r_v3) begin
      if (r_l3) begin
        out_result <= w_acc_next;
        out_beats  <= w_cnt_next;
        out_valid  <= 1'b1;
        r_acc      <= '0;
        r_cnt      <= '0;
      end else begin
        r_acc     <= w_acc_next;
        r_cnt     <= w_cnt_next;
        out_valid <= 1'b0;
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_acc_tree.sv
// -----------------------------------------------------------------------------
// tb_pe_acc_tree
//
// Directed bench for pe_acc_tree. Inputs change 1 ns after a rising edge, and
// outputs are sampled at the same point. A beat driven before edge E0
// therefore produces its out_valid pulse right after edge E0+3.
// -----------------------------------------------------------------------------
module tb_pe_acc_tree;

  localparam int ACC_W = 48;

  logic               clk;
  logic               rst_n;
  logic               mult_valid;
  logic               mult_last;
  logic [1023:0]      mult_result;
  logic               acc_clr;
  logic               out_valid;
  logic [ACC_W-1:0]   out_result;
  logic [15:0]        out_beats;

  int checks = 0;
  int errors = 0;

  pe_acc_tree #(.ACC_W(ACC_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mult_valid  (mult_valid),
    .mult_last   (mult_last),
    .mult_result (mult_result),
    .acc_clr     (acc_clr),
    .out_valid   (out_valid),
    .out_result  (out_result),
    .out_beats   (out_beats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, with every lane set to the same value, then
  // advance past the edge that samples them.
  task automatic drive(input logic v, input logic last, input logic [31:0] lane,
                       input logic clr);
    mult_valid  = v;
    mult_last   = last;
    mult_result = {32{lane}};
    acc_clr     = clr;
    cycle();
  endtask

  task automatic idle_check(input string tag);
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    check(tag, 64'(out_valid), 64'd0);
  endtask

  // Called right after the last beat's edge. Expect quiet, quiet, pulse, quiet.
  task automatic finish_expect(input string tag, input logic [ACC_W-1:0] r,
                               input logic [15:0] b);
    idle_check({tag, "_lat1"});
    idle_check({tag, "_lat2"});
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    check({tag, "_valid"},  64'(out_valid),  64'd1);
    check({tag, "_result"}, 64'(out_result), 64'(r));
    check({tag, "_beats"},  64'(out_beats),  64'(b));
    idle_check({tag, "_after"});
    check({tag, "_hold"}, 64'(out_result), 64'(r));
  endtask

  initial begin
    rst_n       = 1'b0;
    mult_valid  = 1'b0;
    mult_last   = 1'b0;
    mult_result = '0;
    acc_clr     = 1'b0;
    #12;
    check("rst_valid",  64'(out_valid),  64'd0);
    check("rst_result", 64'(out_result), 64'd0);
    check("rst_beats",  64'(out_beats),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Single beat: 32 lanes of 1.
    drive(1'b1, 1'b1, 32'd1, 1'b0);
    finish_expect("single", 48'd32, 16'd1);

    // Four beats of -2 with a bubble that carries a stray last.
    drive(1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0);
    drive(1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0);
    drive(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    drive(1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0);
    drive(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
    finish_expect("bubble", 48'hFFFF_FFFF_FF00, 16'd4);

    // Back-to-back single-beat products.
    drive(1'b1, 1'b1, 32'd3, 1'b0);
    drive(1'b1, 1'b1, 32'd5, 1'b0);
    idle_check("b2b_lat");
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    check("b2b_a_valid",  64'(out_valid),  64'd1);
    check("b2b_a_result", 64'(out_result), 64'd96);
    check("b2b_a_beats",  64'(out_beats),  64'd1);
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    check("b2b_b_valid",  64'(out_valid),  64'd1);
    check("b2b_b_result", 64'(out_result), 64'd160);
    check("b2b_b_beats",  64'(out_beats),  64'd1);
    idle_check("b2b_after");

    // Most negative lanes: 2 * 32 * -2^31 = -2^37.
    drive(1'b1, 1'b0, 32'h8000_0000, 1'b0);
    drive(1'b1, 1'b1, 32'h8000_0000, 1'b0);
    finish_expect("minneg", 48'hFFE0_0000_0000, 16'd2);

    // Most positive lanes: 64 * (2^31 - 1).
    drive(1'b1, 1'b0, 32'h7FFF_FFFF, 1'b0);
    drive(1'b1, 1'b1, 32'h7FFF_FFFF, 1'b0);
    finish_expect("maxpos", 48'h001F_FFFF_FFC0, 16'd2);

    // Soft clear while three beats are in flight, together with a fresh beat.
    drive(1'b1, 1'b0, 32'd1, 1'b0);
    drive(1'b1, 1'b0, 32'd1, 1'b0);
    drive(1'b1, 1'b0, 32'd1, 1'b0);
    drive(1'b1, 1'b1, 32'd2, 1'b1);
    finish_expect("clr", 48'd64, 16'd1);

    // Reset while S1..S3 hold beats and the last beat sits in S1.
    drive(1'b1, 1'b0, 32'd1, 1'b0);
    drive(1'b1, 1'b0, 32'd1, 1'b0);
    drive(1'b1, 1'b1, 32'd1, 1'b0);
    mult_valid = 1'b0;
    mult_last  = 1'b0;
    rst_n      = 1'b0;
    #2;
    check("mrst_valid",  64'(out_valid),  64'd0);
    check("mrst_result", 64'(out_result), 64'd0);
    check("mrst_beats",  64'(out_beats),  64'd0);
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) idle_check("mrst_quiet");
    check("mrst_quiet_result", 64'(out_result), 64'd0);
    drive(1'b1, 1'b1, 32'd1, 1'b0);
    finish_expect("post_rst", 48'd32, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_acc_tree.md
# pe_acc_tree

Pipelined reduction-and-accumulate stage that sits directly downstream of the int16 multiplier array in the parallel PE. Each valid beat carries 32 signed 32-bit lane products; the block sums them through a registered adder tree and accumulates beats into a wide accumulator. At the end of a dot product, marked by `mult_last`, it emits one result with its beat count. There is no backpressure: the consumer must accept every `out_valid` pulse.

## Interface
- `ACC_W`, default 48: accumulator and result width in bits; legal range 40..64.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mult_valid`  in  1  the beat on `mult_result` is valid this cycle.
- `mult_last`  in  1  final beat of the current dot product; ignored when `mult_valid`=0.
- `mult_result`  in  1024  32 lanes, lane i = bits [32i+31:32i], signed two's complement.
- `acc_clr`  in  1  synchronous soft clear: flushes in-flight beats and the accumulator.
- `out_valid`  out  1  one-cycle pulse; result fields are valid in this cycle.
- `out_result`  out  ACC_W  signed dot-product result; holds its value between pulses.
- `out_beats`  out  16  number of valid beats in the result; saturates at 65535.

## Operation
- S1 register: 16 pairwise sums of adjacent lanes (2k, 2k+1), each 33-bit signed, plus `v1` and `l1`.
- S2 register: 4 sums of four S1 values, each 35-bit signed, plus `v2` and `l2`.
- S3 register: 1 sum of all four S2 values, 37-bit signed, plus `v3` and `l3`. This is the exact 32-lane sum; no overflow is possible.
- Accumulate stage, active when `v3`=1:
  - `acc_next = acc + sext(S3 sum to ACC_W)`, computed modulo 2^ACC_W (wraps silently).
  - `cnt_next = min(cnt+1, 65535)`.
  - If `l3`=1: `out_result <= acc_next`, `out_beats <= cnt_next`, `out_valid <= 1`, then `acc <= 0` and `cnt <= 0`, so the next beat starts a fresh dot product.
  - If `l3`=0: `acc <= acc_next`, `cnt <= cnt_next`, `out_valid <= 0`.
- When `v3`=0 (bubble): `acc`, `cnt`, `out_result` and `out_beats` hold; `out_valid <= 0`.
- Bubbles on `mult_valid` travel as `v`=0 through all stages. Data registers may load don't-care values on bubbles, but valid/last bits must be exact.
- `acc_clr`=1 at an edge:
  - `v1`, `v2`, `v3`, `acc`, `cnt` and `out_valid` all go to 0.
  - A beat presented in the same cycle as `acc_clr` is still captured into S1 and becomes the first beat of a new dot product.
  - `out_result` and `out_beats` hold their last values.
- Reset (`rst_n`=0, asynchronous): all valid/last bits, `acc`, `cnt`, `out_valid`, `out_result` and `out_beats` go to 0 immediately. Beats in flight are discarded, and no partial result is ever emitted.

## Timing
- A beat sampled at the end of cycle c appears in S1 during c+1, S2 during c+2, S3 during c+3. If it is the last beat, `out_valid` is high during c+4.
- Fixed latency of 4 cycles from the last beat to `out_valid`, independent of beat count.
- Throughput is one beat per cycle. Back-to-back dot products are allowed, including a single-beat product immediately following another; this gives `out_valid` high on consecutive cycles.
- Reset values: `out_valid`=0, `out_result`=0, `out_beats`=0.
- After `rst_n` deasserts, the first beat may be presented in the next cycle.

## Test plan
- **Single beat:** all lanes = 1, `mult_valid`=`mult_last`=1 in cycle c -> `out_valid` only in c+4, `out_result`=32, `out_beats`=1.
- **Multi-beat with bubbles:**
  - Stimulus: 4 beats with all lanes = 0xFFFFFFFE (-2), a bubble between beats 2 and 3, and `mult_last`=1 on a bubble cycle (must be ignored). `mult_last`=1 on beat 4.
  - Response: exactly one pulse, `out_result`=-256, `out_beats`=4.
- **Back-to-back:** beat A (lanes = 3, last) then beat B (lanes = 5, last) in consecutive cycles -> pulses in c+4 (96, 1) and c+5 (160, 1); B does not include A.
- **Extremes:** 2 beats with all lanes = 0x80000000 -> `out_result` = -2^37 exactly (sign-extended to ACC_W), `out_beats`=2. Also run 2 beats with all lanes = 0x7FFFFFFF -> 64*(2^31-1).
- **Clear:**
  - Stimulus: 3 beats of lanes = 1 without last, then `acc_clr`=1 together with a beat of lanes = 2 and last.
  - Response: result 64 with `out_beats`=1. Beats still in flight at the clear never appear in any result.
- **Reset mid-operation:** assert `rst_n`=0 for 1 cycle while beats occupy S1..S3 with last pending -> outputs are 0 immediately, no `out_valid` follows, and a subsequent single beat (lanes = 1, last) gives 32 / 1.
